// File: rtl/iecdrv_rom_sched.sv
// Shares one dual-image drive ROM read port between NDR emulated 1541 drives.
// Each ph2 window issues one masked read per enabled drive and returns each byte.
module iecdrv_rom_sched #(
    parameter int NDR = 4,
    parameter int LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [NDR-1:0]    i_drv_en,
    input  logic [15*NDR-1:0] i_drv_addr,
    input  logic [1:0]        i_rom_sz,
    input  logic              i_stdrom,
    input  logic [7:0]        i_rom_q,
    input  logic [7:0]        i_ext_q,
    input  logic              i_clr_ovr,
    output logic [14:0]       o_mem_a,
    output logic              o_mem_rd,
    output logic [8*NDR-1:0]  o_drv_data,
    output logic [NDR-1:0]    o_drv_valid,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [1:0]        o_state
);
    localparam int SW = (NDR > 1) ? $clog2(NDR) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NDR-1:0] r_pend;
    logic [NDR-1:0] w_pend_clr;
    logic [1:0]     r_sz_l;
    logic           r_std_l;
    logic [14:0]    r_mem_a;
    logic           r_mem_rd;
    logic [7:0]     r_drv_data [NDR];
    logic [NDR-1:0] r_drv_valid;
    logic           r_overrun;
    logic [LAT-1:0] r_tag_v;
    logic [SW-1:0]  r_tag [LAT];

    logic [14:0]    w_addr [NDR];
    logic [SW-1:0]  w_sel;
    logic [14:0]    w_addr_sel;
    logic [14:0]    w_addr_mask;
    logic           w_issue;
    logic           w_latch;
    logic           w_cap;
    logic           w_ovr_set;
    logic           w_pipe_empty_nxt;
    logic [7:0]     w_cap_data;

    for (genvar gi = 0; gi < NDR; gi++) begin : g_slot
        assign w_addr[gi]              = i_drv_addr[15*gi +: 15];
        assign o_drv_data[8*gi +: 8]   = r_drv_data[gi];
    end

    // Lowest-index pending drive wins the next slot.
    always_comb begin
        w_sel = '0;
        for (int i = NDR - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel = SW'(i);
            end
        end
    end

    assign w_pend_clr  = r_pend & ~(NDR'(1) << w_sel);
    assign w_addr_sel  = w_addr[w_sel];
    // Unused upper address lines are forced low to mirror the ROM image size.
    assign w_addr_mask = {w_addr_sel[14] & r_sz_l[1],
                          w_addr_sel[13] & (r_sz_l[0] | r_std_l),
                          w_addr_sel[12:0]};

    assign w_pipe_empty_nxt = (r_tag_v[LAT-2:0] == '0);
    assign w_ovr_set        = i_start & (r_state != ST_IDLE);
    assign w_cap            = r_tag_v[LAT-1] & ~w_latch;
    assign w_cap_data       = r_std_l ? i_rom_q : i_ext_q;

    // A start in any state begins a fresh window; outside IDLE it aborts the old one.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_latch     = 1'b0;
        if (i_start) begin
            w_latch     = 1'b1;
            w_state_nxt = (i_drv_en == '0) ? ST_DRAIN : ST_ISSUE;
        end else begin
            unique case (r_state)
                ST_ISSUE: begin
                    w_issue = 1'b1;
                    if (w_pend_clr == '0) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty_nxt) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend  <= '0;
            r_sz_l  <= '0;
            r_std_l <= 1'b0;
        end else if (w_latch) begin
            r_pend  <= i_drv_en;
            r_sz_l  <= i_rom_sz;
            r_std_l <= i_stdrom;
        end else if (w_issue) begin
            r_pend  <= w_pend_clr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mem_a  <= '0;
            r_mem_rd <= 1'b0;
        end else begin
            r_mem_rd <= w_issue;
            if (w_issue) begin
                r_mem_a <= w_addr_mask;
            end
        end
    end

    // Tag pipe: a slot tag issued on edge E reaches the last stage for capture at E+LAT.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tag_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_latch) begin
                r_tag_v <= '0;
            end else begin
                r_tag_v <= {r_tag_v[LAT-2:0], w_issue};
            end
            r_tag[0] <= w_sel;
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drv_valid <= '0;
            for (int i = 0; i < NDR; i++) begin
                r_drv_data[i] <= 8'hFF;
            end
        end else begin
            r_drv_valid <= '0;
            if (w_cap) begin
                r_drv_valid               <= NDR'(1) << r_tag[LAT-1];
                r_drv_data[r_tag[LAT-1]]  <= w_cap_data;
            end
        end
    end

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (i_clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_mem_a     = r_mem_a;
    assign o_mem_rd    = r_mem_rd;
    assign o_drv_valid = r_drv_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_overrun   = r_overrun;
    assign o_state     = r_state;

endmodule

// File: tb/tb_iecdrv_rom_sched.sv
// Self-checking bench for iecdrv_rom_sched: table of directed windows, overrun,
// reset and random windows checked cycle by cycle against a window-level model.
module tb_iecdrv_rom_sched;
  localparam int NDR = 4;
  localparam int LAT = 2;
  localparam logic [59:0] ADDRS = {15'h2AAA, 15'h4000, 15'h1234, 15'h7FFF};

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic [NDR-1:0] drv_en;
  logic [15*NDR-1:0] drv_addr;
  logic [1:0] rom_sz;
  logic stdrom;
  logic [7:0] rom_q;
  logic [7:0] ext_q;
  logic clr_ovr;
  logic [14:0] mem_a;
  logic mem_rd;
  logic [8*NDR-1:0] drv_data;
  logic [NDR-1:0] drv_valid;
  logic busy;
  logic overrun;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_data [NDR];
  logic [14:0] m_mem_a;
  logic m_ovr;

  typedef struct {
    bit do_rst;
    logic [NDR-1:0] en;
    logic [1:0] sz;
    logic std;
    logic [15*NDR-1:0] addr;
    logic [14:0] exp_a;
    logic [8*NDR-1:0] exp_data;
  } vec_t;
  vec_t tbl [8];

  iecdrv_rom_sched #(.NDR(NDR), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_drv_en(drv_en),
    .i_drv_addr(drv_addr), .i_rom_sz(rom_sz), .i_stdrom(stdrom),
    .i_rom_q(rom_q), .i_ext_q(ext_q), .i_clr_ovr(clr_ovr),
    .o_mem_a(mem_a), .o_mem_rd(mem_rd), .o_drv_data(drv_data),
    .o_drv_valid(drv_valid), .o_busy(busy), .o_overrun(overrun),
    .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs with one output register: data for mem_a arrives 2 edges later.
  always @(posedge clk) begin
    ext_q <= mem_a[7:0];
    rom_q <= {mem_a[14:8], 1'b1};
  end

  function automatic logic [14:0] f_mask(input logic [14:0] a, input logic [1:0] sz, input logic std);
    logic [14:0] r;
    r = a;
    if (!sz[1]) r[14] = 1'b0;
    if (!(sz[0] || std)) r[13] = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] f_data(input logic [14:0] a, input logic std);
    return std ? {a[14:8], 1'b1} : a[7:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDR; i++) m_data[i] = 8'hFF;
    m_mem_a = '0;
    m_ovr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string nm, input logic e_busy, input logic e_rd, input logic [NDR-1:0] e_valid);
    logic [8*NDR-1:0] ed;
    for (int i = 0; i < NDR; i++) ed[8*i +: 8] = m_data[i];
    chk({nm, "/busy"}, busy, e_busy);
    chk({nm, "/mem_rd"}, mem_rd, e_rd);
    chk({nm, "/valid"}, drv_valid, e_valid);
    chk({nm, "/mem_a"}, mem_a, m_mem_a);
    chk({nm, "/overrun"}, overrun, m_ovr);
    chk({nm, "/data"}, drv_data, ed);
  endtask

  task automatic do_reset();
    start = 1'b0;
    clr_ovr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_cycle("reset", 1'b0, 1'b0, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk_cycle("idle", 1'b0, 1'b0, '0);
    end
  endtask

  // One window from its start edge E0: drive k of the enabled list issues at
  // E(k+1) and returns at E(k+1+LAT); busy falls at E(M+LAT), or E1 if M = 0.
  task automatic run_window(input logic [NDR-1:0] en, input logic [1:0] sz, input logic std,
                            input logic [15*NDR-1:0] addr, input bit rand_addr, input bit restart,
                            output logic [14:0] first_a);
    int lst[$];
    logic [14:0] iss[$];
    int m;
    int last;
    first_a = '0;
    for (int i = 0; i < NDR; i++) if (en[i]) lst.push_back(i);
    m = lst.size();
    last = (m == 0) ? 1 : m + LAT;
    drv_en = en;
    rom_sz = sz;
    stdrom = std;
    drv_addr = rand_addr ? 60'({$urandom(), $urandom()}) : addr;
    start = 1'b1;
    step();
    start = 1'b0;
    if (restart) m_ovr = 1'b1;
    chk_cycle("win_e0", 1'b1, 1'b0, '0);
    for (int t = 1; t <= last; t++) begin
      logic [NDR-1:0] v;
      drv_en = NDR'($urandom());
      rom_sz = 2'($urandom());
      stdrom = 1'($urandom());
      if (rand_addr) drv_addr = 60'({$urandom(), $urandom()});
      if (t <= m) begin
        m_mem_a = f_mask(drv_addr[15*lst[t-1] +: 15], sz, std);
        iss.push_back(m_mem_a);
      end
      step();
      if (t == 1) first_a = mem_a;
      v = '0;
      if (t > LAT && t <= m + LAT) begin
        v[lst[t-1-LAT]] = 1'b1;
        m_data[lst[t-1-LAT]] = f_data(iss[t-1-LAT], std);
      end
      chk_cycle("win", t < last, t <= m, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] fa;
    int k;
    reset_n = 1'b0;
    start = 1'b0;
    clr_ovr = 1'b0;
    drv_en = '0;
    drv_addr = '0;
    rom_sz = '0;
    stdrom = 1'b0;
    do_reset();

    tbl[0] = '{1, 4'hF, 2'b11, 1'b0, ADDRS, 15'h7FFF, 32'hAA0034FF};
    tbl[1] = '{1, 4'hA, 2'b11, 1'b0, ADDRS, 15'h1234, 32'hAAFF34FF};
    tbl[2] = '{0, 4'h1, 2'b00, 1'b0, {ADDRS[59:15], 15'h7F5A}, 15'h1F5A, 32'hAAFF345A};
    tbl[3] = '{0, 4'h1, 2'b01, 1'b0, {ADDRS[59:15], 15'h7F5A}, 15'h3F5A, 32'hAAFF345A};
    tbl[4] = '{0, 4'h1, 2'b00, 1'b1, {ADDRS[59:15], 15'h7F5A}, 15'h3F5A, 32'hAAFF347F};
    tbl[5] = '{0, 4'h1, 2'b11, 1'b1, {ADDRS[59:15], 15'h7F5A}, 15'h7F5A, 32'hAAFF34FF};
    tbl[6] = '{0, 4'h1, 2'b10, 1'b0, {ADDRS[59:15], 15'h7F5A}, 15'h5F5A, 32'hAAFF345A};
    tbl[7] = '{0, 4'h0, 2'b11, 1'b0, ADDRS, 15'h0000, 32'hAAFF345A};

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].do_rst) do_reset();
      idle_cycles(1);
      run_window(tbl[i].en, tbl[i].sz, tbl[i].std, tbl[i].addr, 1'b0, 1'b0, fa);
      chk($sformatf("tbl%0d/data", i), drv_data, tbl[i].exp_data);
      if (tbl[i].en != '0) chk($sformatf("tbl%0d/first_a", i), fa, tbl[i].exp_a);
    end

    // Second start two edges into a full window aborts slot 0's in-flight read.
    do_reset();
    drv_en = 4'hF; rom_sz = 2'b11; stdrom = 1'b0; drv_addr = ADDRS;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_cycle("ov_e0", 1'b1, 1'b0, '0);
    m_mem_a = 15'h7FFF;
    step();
    chk_cycle("ov_e1", 1'b1, 1'b1, '0);
    run_window(4'hF, 2'b11, 1'b0, ADDRS, 1'b0, 1'b1, fa);
    chk("ov/data", drv_data, 32'hAA0034FF);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    m_ovr = 1'b0;
    chk_cycle("ov_clr", 1'b0, 1'b0, '0);

    // Start held two cycles while clr_ovr is high on the second: set wins.
    drv_en = 4'h1; rom_sz = 2'b11; stdrom = 1'b0; drv_addr = ADDRS;
    start = 1'b1;
    step();
    chk_cycle("co_e0", 1'b1, 1'b0, '0);
    clr_ovr = 1'b1;
    step();
    start = 1'b0;
    clr_ovr = 1'b0;
    chk("co/overrun", overrun, 1'b1);
    k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    chk("co/busy_done", busy, 1'b0);
    chk("co/overrun_held", overrun, 1'b1);
    m_ovr = 1'b1;
    m_mem_a = 15'h7FFF;
    m_data[0] = 8'hFF;
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    m_ovr = 1'b0;
    chk_cycle("co_clr", 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of a window.
    do_reset();
    drv_en = 4'hF; rom_sz = 2'b11; stdrom = 1'b0; drv_addr = ADDRS;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_cycle("rm_e0", 1'b1, 1'b0, '0);
    m_mem_a = 15'h7FFF;
    step();
    chk_cycle("rm_e1", 1'b1, 1'b1, '0);
    m_mem_a = 15'h1234;
    step();
    chk_cycle("rm_e2", 1'b1, 1'b1, '0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_cycle("rm_async", 1'b0, 1'b0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(4);

    for (int w = 0; w < 40; w++) begin
      idle_cycles($urandom_range(0, 3));
      run_window(NDR'($urandom()), 2'($urandom()), 1'($urandom()), '0, 1'b1, 1'b0, fa);
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
